// File: rtl/coord_pkg.sv
// Shared types and constants for the coordinate stream accumulators.
package coord_pkg;

  localparam int COORD_WIDTH = 8;
  localparam int COORD_CNT_W = 8;

  // Signed range limits of a default-width coordinate.
  localparam int COORD_MAX = (2 ** (COORD_WIDTH - 1)) - 1;
  localparam int COORD_MIN = -(2 ** (COORD_WIDTH - 1));

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } coord_state_e;

endpackage

// File: rtl/coord_stream_acc_if.sv
// Control and output-stream bundle of one coordinate stream accumulator.
// master: sequencer / downstream side; slave: the accumulator itself.
interface coord_stream_acc_if import coord_pkg::*; #(
  parameter int WIDTH = COORD_WIDTH,
  parameter int CNT_W = COORD_CNT_W
) ();

  logic                    START;
  logic                    ABORT;
  logic signed [WIDTH-1:0] ORIGIN;
  logic signed [WIDTH-1:0] STEP;
  logic [CNT_W-1:0]        COUNT;
  logic                    OUT_READY;
  logic                    OUT_VALID;
  logic signed [WIDTH-1:0] COORD_OUT;
  logic                    OUT_LAST;
  logic                    BUSY;
  logic                    OVF;

  modport master (
    output START, ABORT, ORIGIN, STEP, COUNT, OUT_READY,
    input  OUT_VALID, COORD_OUT, OUT_LAST, BUSY, OVF
  );

  modport slave (
    input  START, ABORT, ORIGIN, STEP, COUNT, OUT_READY,
    output OUT_VALID, COORD_OUT, OUT_LAST, BUSY, OVF
  );

endinterface

// File: rtl/coord_sat_add.sv
// Combinational signed adder with overflow detect.
// Build option COORD_STREAM_SAT_EN: clamp to the signed range on overflow;
// otherwise the result wraps (low WIDTH bits of the sum).
module coord_sat_add import coord_pkg::*; #(
  parameter int WIDTH = COORD_WIDTH
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    ovf
);

  logic signed [WIDTH:0] sum_ext;

  // Add with one guard bit; guard and sign bits disagree exactly on overflow,
  // and the guard bit then gives the true sign (overflow direction).
  always_comb begin
    sum_ext = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    ovf     = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
`ifdef COORD_STREAM_SAT_EN
    if (ovf) begin
      sum = sum_ext[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      sum = sum_ext[WIDTH-1:0];
    end
`else
    sum = sum_ext[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/coord_stream_acc.sv
// Coordinate stream accumulator: emits ORIGIN, ORIGIN+STEP, ... (COUNT beats)
// over a valid/ready stream. One instance per axis.
// Build option COORD_STREAM_SAT_EN selects saturating accumulation.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no sweep; waits for START with nonzero COUNT (ABORT blocks it)
// RUN   | beat valid on COORD_OUT; advances on each accepted transfer
module coord_stream_acc import coord_pkg::*; #(
  parameter int WIDTH = COORD_WIDTH,
  parameter int CNT_W = COORD_CNT_W
) (
  input logic               CLK,
  input logic               RST_ASYNC_N,
  coord_stream_acc_if.slave bus
);

  coord_state_e            state_q, state_d;
  logic signed [WIDTH-1:0] coord_q, coord_d;
  logic signed [WIDTH-1:0] step_q,  step_d;
  logic [CNT_W-1:0]        rem_q,   rem_d;
  logic                    ovf_q,   ovf_d;

  logic signed [WIDTH-1:0] add_sum;
  logic                    add_ovf;
  logic                    last_beat;

  coord_sat_add #(.WIDTH(WIDTH)) u_add (
    .a   (coord_q),
    .b   (step_q),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign last_beat = (rem_q == CNT_W'(1));

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      state_q <= IDLE;
      coord_q <= '0;
      step_q  <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      coord_q <= coord_d;
      step_q  <= step_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: sweep launch, per-transfer accumulate, abort and completion.
  // The final beat never adds, so its overflow flag cannot be raised there.
  always_comb begin
    state_d = state_q;
    coord_d = coord_q;
    step_d  = step_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START && !bus.ABORT && (bus.COUNT != '0)) begin
          state_d = RUN;
          coord_d = bus.ORIGIN;
          step_d  = bus.STEP;
          rem_d   = bus.COUNT;
          ovf_d   = 1'b0;
        end
      end
      RUN: begin
        if (bus.ABORT) begin
          state_d = IDLE;
        end else if (bus.OUT_READY) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            coord_d = add_sum;
            rem_d   = rem_q - CNT_W'(1);
            if (add_ovf) begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stream outputs come only from registers, never from OUT_READY.
  assign bus.OUT_VALID = (state_q == RUN);
  assign bus.BUSY      = (state_q == RUN);
  assign bus.OUT_LAST  = (state_q == RUN) && last_beat;
  assign bus.COORD_OUT = coord_q;
  assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_coord_stream_acc.sv
// Randomised bench for coord_stream_acc against a list-based sweep model.
module tb_coord_stream_acc;
  import coord_pkg::*;

  localparam int W  = COORD_WIDTH;
  localparam int CW = COORD_CNT_W;
`ifdef COORD_STREAM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_v[$];
  bit   exp_o[$];

  always #5 clk = ~clk;

  coord_stream_acc_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  coord_stream_acc #(.WIDTH(W), .CNT_W(CW)) dut (
    .CLK         (clk),
    .RST_ASYNC_N (rst_n),
    .bus         (bus)
  );

  task automatic expect_eq(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected beat list and the sticky overflow flag seen alongside each beat.
  function automatic void model(int origin, int step, int count);
    int v;
    int s;
    bit o;
    exp_v.delete();
    exp_o.delete();
    v = origin;
    o = 1'b0;
    for (int i = 0; i < count; i++) begin
      exp_v.push_back(v);
      exp_o.push_back(o);
      if (i < count - 1) begin
        s = v + step;
        if (s > COORD_MAX) begin
          o = 1'b1;
          v = SAT_EN ? COORD_MAX : s - (1 << W);
        end else if (s < COORD_MIN) begin
          o = 1'b1;
          v = SAT_EN ? COORD_MIN : s + (1 << W);
        end else begin
          v = s;
        end
      end
    end
  endfunction

  // Called at a negedge with the DUT idle. rmode: 0 ready always, 1 pattern
  // 1,0,0, 2 random. spam: random START during the sweep. abort_at: beat
  // index at which ABORT is raised (-1 none). chain: raise START with the
  // n_* parameters in the final-transfer cycle and leave it high.
  task automatic run_sweep(int origin, int step, int count, int rmode, bit spam,
                           int abort_at, bit chain, int n_origin, int n_step, int n_count);
    int idx = 0;
    int cyc = 0;
    int end_idx;
    bit rdy;
    bit aborted = 1'b0;
    model(origin, step, count);
    bus.ORIGIN = W'(origin);
    bus.STEP   = W'(step);
    bus.COUNT  = CW'(count);
    bus.START  = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    while (idx < count && cyc < 200) begin
      expect_eq("valid", bus.OUT_VALID, 1);
      expect_eq("busy", bus.BUSY, 1);
      expect_eq("coord", bus.COORD_OUT, exp_v[idx]);
      expect_eq("last", bus.OUT_LAST, (idx == count - 1) ? 1 : 0);
      expect_eq("ovf_run", bus.OVF, exp_o[idx]);
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (spam) begin
        bus.START  = 1'($urandom_range(0, 1));
        bus.ORIGIN = W'($urandom);
        bus.COUNT  = CW'($urandom_range(1, 5));
      end
      if (chain && idx == count - 1) begin
        bus.START  = 1'b1;
        bus.ORIGIN = W'(n_origin);
        bus.STEP   = W'(n_step);
        bus.COUNT  = CW'(n_count);
      end
      if (idx == abort_at) begin
        bus.ABORT = 1'b1;
        rdy       = 1'b1;
        aborted   = 1'b1;
      end
      bus.OUT_READY = rdy;
      @(negedge clk);
      cyc++;
      bus.ABORT = 1'b0;
      if (aborted) break;
      if (rdy) idx++;
    end
    if (!chain) bus.START = 1'b0;
    end_idx = aborted ? abort_at : count - 1;
    if (!aborted) expect_eq("beats", idx, count);
    expect_eq("idle_valid", bus.OUT_VALID, 0);
    expect_eq("idle_busy", bus.BUSY, 0);
    expect_eq("idle_last", bus.OUT_LAST, 0);
    expect_eq("hold_coord", bus.COORD_OUT, exp_v[end_idx]);
    expect_eq("hold_ovf", bus.OVF, exp_o[end_idx]);
    bus.OUT_READY = 1'($urandom_range(0, 1));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.START     = 1'b0;
    bus.ABORT     = 1'b0;
    bus.ORIGIN    = '0;
    bus.STEP      = '0;
    bus.COUNT     = '0;
    bus.OUT_READY = 1'b0;
    #12;
    expect_eq("rst_valid", bus.OUT_VALID, 0);
    expect_eq("rst_coord", bus.COORD_OUT, 0);
    expect_eq("rst_last", bus.OUT_LAST, 0);
    expect_eq("rst_busy", bus.BUSY, 0);
    expect_eq("rst_ovf", bus.OVF, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed sweeps.
    run_sweep(10, 3, 4, 0, 1'b0, -1, 1'b0, 0, 0, 0);
    run_sweep(10, 3, 4, 1, 1'b0, -1, 1'b0, 0, 0, 0);
    run_sweep(120, 5, 3, 0, 1'b0, -1, 1'b0, 0, 0, 0);
    run_sweep(-120, -5, 3, 2, 1'b0, -1, 1'b0, 0, 0, 0);
    run_sweep(0, -2, 3, 0, 1'b0, -1, 1'b0, 0, 0, 0);

    // START with COUNT=0 is ignored.
    bus.START = 1'b1;
    bus.COUNT = '0;
    @(negedge clk);
    bus.START = 1'b0;
    expect_eq("cnt0_busy", bus.BUSY, 0);
    expect_eq("cnt0_valid", bus.OUT_VALID, 0);
    @(negedge clk);
    expect_eq("cnt0_busy2", bus.BUSY, 0);

    // START during RUN ignored; START in the final-transfer cycle ignored,
    // the same START held one more cycle is accepted.
    run_sweep(-5, 7, 6, 2, 1'b1, -1, 1'b0, 0, 0, 0);
    run_sweep(30, 4, 3, 0, 1'b0, -1, 1'b1, 50, -9, 2);
    run_sweep(50, -9, 2, 0, 1'b0, -1, 1'b0, 0, 0, 0);

    // ABORT on beat 2 of 5 together with a transfer.
    run_sweep(7, 1, 5, 0, 1'b0, 1, 1'b0, 0, 0, 0);
    run_sweep(125, 2, 5, 0, 1'b0, 2, 1'b0, 0, 0, 0);

    // ABORT in IDLE blocks a simultaneous START.
    bus.ABORT  = 1'b1;
    bus.START  = 1'b1;
    bus.ORIGIN = W'(3);
    bus.COUNT  = CW'(3);
    @(negedge clk);
    bus.ABORT = 1'b0;
    bus.START = 1'b0;
    expect_eq("abort_idle_busy", bus.BUSY, 0);
    expect_eq("abort_idle_valid", bus.OUT_VALID, 0);

    // Asynchronous reset between edges mid-sweep, after an overflow.
    bus.ORIGIN    = W'(126);
    bus.STEP      = W'(1);
    bus.COUNT     = CW'(10);
    bus.OUT_READY = 1'b1;
    bus.START     = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    @(negedge clk);
    @(negedge clk);
    expect_eq("pre_rst_ovf", bus.OVF, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_eq("mid_rst_valid", bus.OUT_VALID, 0);
    expect_eq("mid_rst_coord", bus.COORD_OUT, 0);
    expect_eq("mid_rst_last", bus.OUT_LAST, 0);
    expect_eq("mid_rst_busy", bus.BUSY, 0);
    expect_eq("mid_rst_ovf", bus.OVF, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_eq("post_rst_busy", bus.BUSY, 0);

    // Random sweeps.
    for (int k = 0; k < 30; k++) begin
      int o;
      int s;
      int c;
      int m;
      int ab;
      o  = int'($urandom_range(0, 255)) - 128;
      s  = int'($urandom_range(0, 80)) - 40;
      c  = int'($urandom_range(1, 10));
      m  = int'($urandom_range(0, 2));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, c - 1)) : -1;
      run_sweep(o, s, c, m, 1'($urandom_range(0, 1)), ab, 1'b0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
